// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
//   Frame controller behind the UART receiver. It hunts for SYNC_BYTE and then
//   collects address, length, payload and checksum. When the checksum matches,
//   it replays the payload as a burst of handshaked register writes.
//
//   Frame on the wire: SYNC, ADDR, LEN, DATA[0..LEN-1], CHK
//   where CHK = (ADDR + LEN + sum(DATA)) mod 256.
//
// Ports
//   clk, rst           system clock; synchronous active-high reset
//   rx_valid, rx_data  one-cycle byte strobe and byte from the receiver
//   rx_error           one-cycle framing-error strobe from the receiver
//   wr_valid, wr_addr, wr_data, wr_ready
//                      register-bus write channel
//   frame_ok           one-cycle pulse when every write of a frame is accepted
//   frame_err          one-cycle pulse when a frame is discarded
//   err_code           last error cause: 0 checksum, 1 length, 2 timeout,
//                      3 line error; holds until the next error
//   busy               high in every state except HUNT
//   dbg_state          current FSM state, for observation only
//
// Write handshake: a write transfers on every rising edge where wr_valid and
// wr_ready are both high. Once wr_valid rises, it stays high and wr_addr and
// wr_data stay constant until that transfer happens. Only rst can drop a write
// that has been offered.
module uart_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [19:0] TO_LIM    = 20'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  base;
    logic [4:0]  len;
    logic [7:0]  sum;
    logic [3:0]  idx;
    logic [19:0] tcnt;
    logic [7:0]  buf_mem [0:15];

    logic collecting;
    logic timed_out;
    logic last_idx;
    logic buf_we;

    assign collecting = (state == ST_ADDR) || (state == ST_LEN) ||
                        (state == ST_DATA) || (state == ST_CHK);
    // Timeout outranks rx_error and rx_valid in the same cycle.
    assign timed_out  = collecting && (tcnt == TO_LIM);
    assign last_idx   = ({1'b0, idx} == (len - 5'd1));
    assign buf_we     = (state == ST_DATA) && rx_valid && !rx_error && !timed_out;
    assign dbg_state  = state;

    // Payload buffer is not reset; its contents are only read after being written.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[idx] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HUNT;
            wr_valid  <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
            busy      <= 1'b0;
            base      <= 8'h00;
            len       <= 5'd0;
            sum       <= 8'h00;
            idx       <= 4'd0;
            tcnt      <= 20'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            // The inter-byte timer clears on any received byte outside COMMIT.
            // It counts only while collecting a frame.
            if (rx_valid && state != ST_COMMIT) begin
                tcnt <= 20'd0;
            end else if (collecting) begin
                tcnt <= tcnt + 20'd1;
            end

            case (state)
                ST_HUNT: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state <= ST_ADDR;
                        busy  <= 1'b1;
                    end
                end

                ST_COMMIT: begin
                    // wr_valid is always high in this state.
                    if (wr_ready) begin
                        if (last_idx) begin
                            wr_valid <= 1'b0;
                            frame_ok <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_HUNT;
                        end else begin
                            idx     <= idx + 4'd1;
                            wr_addr <= base + {4'b0000, idx} + 8'd1;
                            wr_data <= buf_mem[idx + 4'd1];
                        end
                    end
                end

                default: begin
                    if (timed_out) begin
                        state     <= ST_HUNT;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        err_code  <= 2'd2;
                    end else if (rx_error) begin
                        state     <= ST_HUNT;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        err_code  <= 2'd3;
                    end else if (rx_valid) begin
                        case (state)
                            ST_ADDR: begin
                                base  <= rx_data;
                                sum   <= rx_data;
                                state <= ST_LEN;
                            end
                            ST_LEN: begin
                                if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                                    state     <= ST_HUNT;
                                    busy      <= 1'b0;
                                    frame_err <= 1'b1;
                                    err_code  <= 2'd1;
                                end else begin
                                    len   <= rx_data[4:0];
                                    sum   <= sum + rx_data;
                                    idx   <= 4'd0;
                                    state <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                sum <= sum + rx_data;
                                idx <= idx + 4'd1;
                                if (last_idx) begin
                                    state <= ST_CHK;
                                end
                            end
                            ST_CHK: begin
                                if (rx_data == sum) begin
                                    state    <= ST_COMMIT;
                                    idx      <= 4'd0;
                                    wr_valid <= 1'b1;
                                    wr_addr  <= base;
                                    wr_data  <= buf_mem[0];
                                end else begin
                                    state     <= ST_HUNT;
                                    busy      <= 1'b0;
                                    frame_err <= 1'b1;
                                    err_code  <= 2'd0;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
